// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the ALU instruction sequencer
// Purpose: state encoding, supported opcodes, IR field positions and
//          opcode class helpers used by the sequencer and its bench.
// Ports:   none (package)
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  // Binary ALU opcodes form one contiguous block (add .. or).
  function automatic logic op_is_binary(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic op_is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - start/done handshake and datapath strobe bundle
// Purpose: groups the sequencer's control handshake and CPU_Datapath strobes.
// Signals: start, IR (from top level / datapath); busy, done, illegal,
//          R_in/R_out one-hot enables, fetch/execute strobes, ALUSelection.
// Modports: master = top level driving start/IR; slave = the sequencer.
interface alu_op_sequencer_if;
  logic        start;
  logic [31:0] IR;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, ZLOin, ZLOout, ZHIout, LOin, HIin;
  logic [4:0]  ALUSelection;

  modport master (
    output start, IR,
    input  busy, done, illegal, R_in, R_out,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    input  Yin, Zin, ZLOin, ZLOout, ZHIout, LOin, HIin, ALUSelection
  );

  modport slave (
    input  start, IR,
    output busy, done, illegal, R_in, R_out,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    output Yin, Zin, ZLOin, ZLOout, ZHIout, LOin, HIin, ALUSelection
  );
endinterface

// File: rtl/reg_field_decoder.sv
// rtl/reg_field_decoder.sv - 4-bit register index to 16-bit one-hot enable
// Purpose: turns a register field into a one-hot strobe vector, all zero
//          when not enabled.
// Ports:   idx_i    in  4   register index
//          en_i     in  1   enable
//          onehot_o out 16  one-hot (bit idx_i set when en_i)
module reg_field_decoder (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - fetch/execute strobe sequencer for register ALU ops
// Purpose: steps T0..T6 one per clock, driving CPU_Datapath strobes from the
//          registered state (Moore outputs).
// Ports:   clk  in  system clock
//          clr  in  synchronous active-high reset
//          bus  slave modport of alu_op_sequencer_if (start/IR in, strobes out)
// Params:  READ_WAIT  extra cycles held in T1 before IR capture (0..7)
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              clr,
  alu_op_sequencer_if.slave bus
);

  localparam logic [2:0] WAIT_MAX = 3'(READ_WAIT);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       op_bin, op_md, op_un, op_legal;
  logic       unused_ir;

  assign op = bus.IR[OP_LSB +: 5];
  assign ra = bus.IR[RA_LSB +: 4];
  assign rb = bus.IR[RB_LSB +: 4];
  assign rc = bus.IR[RC_LSB +: 4];
  assign unused_ir = ^bus.IR[RC_LSB-1:0];

  assign op_bin   = op_is_binary(op);
  assign op_md    = op_is_muldiv(op);
  assign op_un    = op_is_unary(op);
  assign op_legal = op_bin | op_md | op_un;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        // Counter only ever reaches WAIT_MAX, so equality is the saturation point.
        if (wait_q == WAIT_MAX) begin
          state_d = ST_T2;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (!op_legal)  state_d = ST_IDLE;
        else if (op_un) state_d = ST_T5;
        else            state_d = ST_T4;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5:   state_d = op_md ? ST_T6 : ST_IDLE;
      ST_T6:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic       rin_en, rout_en;
  logic [3:0] rout_idx;

  always_comb begin
    bus.busy         = (state_q != ST_IDLE);
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;
    bus.PCout        = 1'b0;
    bus.MARin        = 1'b0;
    bus.IncPC        = 1'b0;
    bus.PCin         = 1'b0;
    bus.Read         = 1'b0;
    bus.MDRin        = 1'b0;
    bus.MDRout       = 1'b0;
    bus.IRin         = 1'b0;
    bus.Yin          = 1'b0;
    bus.Zin          = 1'b0;
    bus.ZLOin        = 1'b0;
    bus.ZLOout       = 1'b0;
    bus.ZHIout       = 1'b0;
    bus.LOin         = 1'b0;
    bus.HIin         = 1'b0;
    bus.ALUSelection = 5'b00000;
    rin_en           = 1'b0;
    rout_en          = 1'b0;
    rout_idx         = rb;
    case (state_q)
      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        bus.ZLOin = 1'b1;
      end
      ST_T1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = 1'b1;
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      ST_T3: begin
        if (!op_legal) begin
          bus.illegal = 1'b1;
        end else begin
          rout_en = 1'b1;
          if (op_un) begin
            // Unary ops feed the ALU directly from Rb; no Y operand needed.
            bus.ALUSelection = op;
            bus.Zin          = 1'b1;
            bus.ZLOin        = 1'b1;
          end else begin
            bus.Yin = 1'b1;
          end
        end
      end
      ST_T4: begin
        rout_en          = 1'b1;
        rout_idx         = rc;
        bus.ALUSelection = op;
        bus.Zin          = 1'b1;
        bus.ZLOin        = 1'b1;
      end
      ST_T5: begin
        bus.ZLOout = 1'b1;
        if (op_md) begin
          bus.LOin = 1'b1;
        end else begin
          rin_en   = 1'b1;
          bus.done = 1'b1;
        end
      end
      ST_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
        bus.done   = 1'b1;
      end
      default: ;
    endcase
  end

  reg_field_decoder u_rin_dec (
    .idx_i    (ra),
    .en_i     (rin_en),
    .onehot_o (bus.R_in)
  );

  reg_field_decoder u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (bus.R_out)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus_m ();
  alu_op_sequencer_if bus_a ();
  alu_op_sequencer_if bus_b ();

  alu_op_sequencer #(.READ_WAIT(1)) u_dut (.clk(clk), .clr(clr), .bus(bus_m.slave));
  alu_op_sequencer #(.READ_WAIT(0)) u_rw0 (.clk(clk), .clr(clr), .bus(bus_a.slave));
  alu_op_sequencer #(.READ_WAIT(3)) u_rw3 (.clk(clk), .clr(clr), .bus(bus_b.slave));

  typedef struct packed {
    logic        busy, done, illegal;
    logic [15:0] r_in, r_out;
    logic        pcout, marin, incpc, pcin, read, mdrin, mdrout, irin;
    logic        yin, zin, zloin, zloout, zhiout, loin, hiin;
    logic [4:0]  alu;
  } snap_t;

  typedef struct {
    int id;
    int act;
    int exp;
  } dchk_t;

  localparam logic [8:0] F_YIN = 9'h100, F_ZIN = 9'h080, F_ZLOIN = 9'h040,
                         F_ZLOOUT = 9'h020, F_ZHIOUT = 9'h010, F_LOIN = 9'h008,
                         F_HIIN = 9'h004, F_DONE = 9'h002, F_ILL = 9'h001;

  snap_t exp_q[$];
  dchk_t dchk_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;
  snap_t act_s, exp_s;
  dchk_t d_s;

  function automatic snap_t grab();
    snap_t s;
    s.busy = bus_m.busy;     s.done = bus_m.done;     s.illegal = bus_m.illegal;
    s.r_in = bus_m.R_in;     s.r_out = bus_m.R_out;
    s.pcout = bus_m.PCout;   s.marin = bus_m.MARin;   s.incpc = bus_m.IncPC;
    s.pcin = bus_m.PCin;     s.read = bus_m.Read;     s.mdrin = bus_m.MDRin;
    s.mdrout = bus_m.MDRout; s.irin = bus_m.IRin;     s.yin = bus_m.Yin;
    s.zin = bus_m.Zin;       s.zloin = bus_m.ZLOin;   s.zloout = bus_m.ZLOout;
    s.zhiout = bus_m.ZHIout; s.loin = bus_m.LOin;     s.hiin = bus_m.HIin;
    s.alu = bus_m.ALUSelection;
    return s;
  endfunction

  function automatic snap_t ex(logic [15:0] rin, logic [15:0] rout, logic [4:0] alu,
                               logic [8:0] f);
    snap_t s = '0;
    s.busy = 1'b1;
    s.r_in = rin;  s.r_out = rout;  s.alu = alu;
    {s.yin, s.zin, s.zloin, s.zloout, s.zhiout, s.loin, s.hiin, s.done, s.illegal} = f;
    return s;
  endfunction

  // Leading idle entry is the cycle in which start is sampled.
  task automatic push_fetch(int rw);
    snap_t s;
    exp_q.push_back('0);
    s = '0; s.busy = 1; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1; s.zloin = 1;
    exp_q.push_back(s);
    s = '0; s.busy = 1; s.zloout = 1; s.pcin = 1; s.read = 1; s.mdrin = 1;
    for (int i = 0; i <= rw; i++) exp_q.push_back(s);
    s = '0; s.busy = 1; s.mdrout = 1; s.irin = 1;
    exp_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(logic [31:0] v);
    bus_m.IR = v; bus_a.IR = v; bus_b.IR = v;
  endtask

  task automatic push_d(int id, int act, int exp);
    dchk_t d;
    d.id = id; d.act = act; d.exp = exp;
    dchk_q.push_back(d);
  endtask

  task automatic drain(int id);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      push_d(id, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      act_s = grab();
      exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks = checks + 1;
      if (act_s !== exp_s) begin
        failures = failures + 1;
        $display("FAIL step_outputs got=%h expected=%h", act_s, exp_s);
      end
    end
    while (dchk_q.size() > 0) begin
      d_s = dchk_q.pop_front();
      checks = checks + 1;
      if (d_s.act != d_s.exp) begin
        failures = failures + 1;
        $display("FAIL direct_check_%0d got=%0d expected=%0d", d_s.id, d_s.act, d_s.exp);
      end
    end
  end

  initial begin
    clr = 1'b1;
    bus_m.start = 1'b0; bus_a.start = 1'b0; bus_b.start = 1'b0;
    set_ir(32'h0);
    repeat (2) tick();
    clr = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();

    // shr Ra=1 Rb=2 Rc=3
    set_ir(32'h28918000);
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0004, 5'b00000, F_YIN));
    exp_q.push_back(ex(16'h0000, 16'h0008, 5'b00101, F_ZIN | F_ZLOIN));
    exp_q.push_back(ex(16'h0002, 16'h0000, 5'b00000, F_ZLOOUT | F_DONE));
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    drain(100);

    // mul Ra=5 Rb=5 Rc=3
    set_ir({5'b01111, 4'd5, 4'd5, 4'd3, 15'b0});
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0020, 5'b00000, F_YIN));
    exp_q.push_back(ex(16'h0000, 16'h0008, 5'b01111, F_ZIN | F_ZLOIN));
    exp_q.push_back(ex(16'h0000, 16'h0000, 5'b00000, F_ZLOOUT | F_LOIN));
    exp_q.push_back(ex(16'h0000, 16'h0000, 5'b00000, F_ZHIOUT | F_HIIN | F_DONE));
    exp_q.push_back('0);
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    drain(101);

    // neg Ra=7 Rb=4
    set_ir({5'b10001, 4'd7, 4'd4, 19'b0});
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0010, 5'b10001, F_ZIN | F_ZLOIN));
    exp_q.push_back(ex(16'h0080, 16'h0000, 5'b00000, F_ZLOOUT | F_DONE));
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    drain(102);

    // illegal opcode, with a start pulse during T1 that must be ignored
    set_ir({5'b11111, 27'h5a5a5a5});
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0000, 5'b00000, F_ILL));
    exp_q.push_back('0);
    exp_q.push_back('0);
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    tick();
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    drain(103);

    // add aborted by clr in T4, then a clean full add
    set_ir({5'b00011, 4'd1, 4'd2, 4'd3, 15'b0});
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0004, 5'b00000, F_YIN));
    exp_q.push_back(ex(16'h0000, 16'h0008, 5'b00011, F_ZIN | F_ZLOIN));
    exp_q.push_back('0);
    exp_q.push_back('0);
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    repeat (5) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    drain(104);
    push_fetch(1);
    exp_q.push_back(ex(16'h0000, 16'h0004, 5'b00000, F_YIN));
    exp_q.push_back(ex(16'h0000, 16'h0008, 5'b00011, F_ZIN | F_ZLOIN));
    exp_q.push_back(ex(16'h0002, 16'h0000, 5'b00000, F_ZLOOUT | F_DONE));
    bus_m.start = 1'b1; tick(); bus_m.start = 1'b0;
    drain(105);

    // back-to-back adds with start held through the done cycle
    for (int k = 0; k < 2; k++) begin
      push_fetch(1);
      exp_q.push_back(ex(16'h0000, 16'h0004, 5'b00000, F_YIN));
      exp_q.push_back(ex(16'h0000, 16'h0008, 5'b00011, F_ZIN | F_ZLOIN));
      exp_q.push_back(ex(16'h0002, 16'h0000, 5'b00000, F_ZLOOUT | F_DONE));
    end
    bus_m.start = 1'b1;
    repeat (9) tick();
    bus_m.start = 1'b0;
    drain(106);

    // READ_WAIT=0 and =3 builds: Read run length, then back-to-back spacing
    begin
      int ra = 0, rb = 0, rra = 0, rrb = 0, t1 = -1, t2 = -1;
      logic pa = 1'b0, pb = 1'b0;
      bus_a.start = 1'b1; bus_b.start = 1'b1; tick();
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      repeat (20) begin
        @(negedge clk);
        ra += int'(bus_a.Read);
        rb += int'(bus_b.Read);
        if (bus_a.Read && !pa) rra++;
        if (bus_b.Read && !pb) rrb++;
        pa = bus_a.Read;
        pb = bus_b.Read;
      end
      tick();
      push_d(1, ra, 1);
      push_d(2, rb, 4);
      push_d(3, rra, 1);
      push_d(4, rrb, 1);
      push_d(5, int'(bus_a.busy) + int'(bus_b.busy), 0);
      bus_a.start = 1'b1; bus_b.start = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus_a.done) begin
          if (t1 < 0) t1 = c;
          else if (t2 < 0) t2 = c;
        end
      end
      tick();
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      push_d(6, t2 - t1, 7);
      push_d(7, (t1 >= 0) ? 1 : 0, 1);
      repeat (20) tick();
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
